// File: rtl/ripple_carry_adder_if.sv
// Operand/result bundle for ripple_carry_adder.
// The master drives the operands; the slave (the adder) returns registered results.
interface ripple_carry_adder_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin,
    input  out_valid, sum, carry, overflow
  );

  modport slave (
    input  in_valid, a, b, cin,
    output out_valid, sum, carry, overflow
  );
endinterface

// File: rtl/ripple_carry_adder.sv
// Registered WIDTH-bit ripple-carry adder, one operation per cycle, 1-cycle latency.
// Define RCA_OVERFLOW_EN to build signed-overflow detection; otherwise overflow is tied to 0.
module ripple_carry_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ripple_carry_adder_if.slave  bus
);

  logic [WIDTH:0]   c_chain;
  logic [WIDTH-1:0] sum_comb;

  // Explicit cell-by-cell carry chain; each iteration is one full adder.
  always_comb begin
    c_chain    = '0;
    sum_comb   = '0;
    c_chain[0] = bus.cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum_comb[i]  = bus.a[i] ^ bus.b[i] ^ c_chain[i];
      c_chain[i+1] = (bus.a[i] & bus.b[i]) | (c_chain[i] & (bus.a[i] ^ bus.b[i]));
    end
  end

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  always_comb begin
    valid_d = bus.in_valid;
    sum_d   = sum_q;
    carry_d = carry_q;
    if (bus.in_valid) begin
      sum_d   = sum_comb;
      carry_d = c_chain[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;

`ifdef RCA_OVERFLOW_EN
  logic overflow_q, overflow_d;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_comb begin
    overflow_d = overflow_q;
    if (bus.in_valid) begin
      overflow_d = c_chain[WIDTH] ^ c_chain[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign bus.overflow = overflow_q;
`else
  assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard bench for ripple_carry_adder at WIDTH 4 (directed + exhaustive), 1 and 32 (random).
module tb_ripple_carry_adder;

`ifdef RCA_OVERFLOW_EN
  localparam bit OvEn = 1'b1;
`else
  localparam bit OvEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ripple_carry_adder_if #(.WIDTH(4))  if4 ();
  ripple_carry_adder_if #(.WIDTH(1))  if1 ();
  ripple_carry_adder_if #(.WIDTH(32)) if32 ();

  ripple_carry_adder #(.WIDTH(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  ripple_carry_adder #(.WIDTH(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  ripple_carry_adder #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  int checks = 0;
  int errors = 0;

  logic [5:0]  q4[$];   // {ovf, carry, sum}
  logic [2:0]  q1[$];
  logic [33:0] q32[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got out_valid=1 expected no pending result", name);
  endtask

  function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [4:0] r;
    r = {1'b0, a} + {1'b0, b} + {4'b0, ci};
    return {OvEn & (a[3] == b[3]) & (r[3] != a[3]), r};
  endfunction

  function automatic logic [2:0] model1(input logic a, input logic b, input logic ci);
    logic [1:0] r;
    r = {1'b0, a} + {1'b0, b} + {1'b0, ci};
    return {OvEn & (a == b) & (r[0] != a), r};
  endfunction

  function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic ci);
    logic [32:0] r;
    r = {1'b0, a} + {1'b0, b} + {32'b0, ci};
    return {OvEn & (a[31] == b[31]) & (r[31] != a[31]), r};
  endfunction

  // Drive one cycle at the falling edge; push expectations only for real, kept operations.
  task automatic step(input bit v, input bit push, input logic [3:0] a, input logic [3:0] b,
                      input logic ci, input logic [5:0] e4);
    logic [31:0] ra32, rb32;
    logic        ra1, rb1;
    ra32 = $urandom;
    rb32 = $urandom;
    ra1  = 1'($urandom_range(0, 1));
    rb1  = 1'($urandom_range(0, 1));
    @(negedge clk);
    if4.in_valid  = v;   if4.a  = a;    if4.b  = b;    if4.cin  = ci;
    if1.in_valid  = v;   if1.a  = ra1;  if1.b  = rb1;  if1.cin  = ci;
    if32.in_valid = v;   if32.a = ra32; if32.b = rb32; if32.cin = ci;
    if (v && push) begin
      q4.push_back(e4);
      q1.push_back(model1(ra1, rb1, ci));
      q32.push_back(model32(ra32, rb32, ci));
    end
  endtask

  always @(negedge clk) begin
    if (if4.out_valid === 1'b1) begin
      if (q4.size() == 0) unexpected("w4_result");
      else chk("w4_result", {58'b0, if4.overflow, if4.carry, if4.sum}, {58'b0, q4.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (if1.out_valid === 1'b1) begin
      if (q1.size() == 0) unexpected("w1_result");
      else chk("w1_result", {61'b0, if1.overflow, if1.carry, if1.sum}, {61'b0, q1.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (if32.out_valid === 1'b1) begin
      if (q32.size() == 0) unexpected("w32_result");
      else chk("w32_result", {30'b0, if32.overflow, if32.carry, if32.sum},
               {30'b0, q32.pop_front()});
    end
  end

  initial begin
    rst_n = 1'b0;
    if4.in_valid  = 1'b0; if4.a  = '0; if4.b  = '0; if4.cin  = 1'b0;
    if1.in_valid  = 1'b0; if1.a  = '0; if1.b  = '0; if1.cin  = 1'b0;
    if32.in_valid = 1'b0; if32.a = '0; if32.b = '0; if32.cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_w4", {57'b0, if4.out_valid, if4.overflow, if4.carry, if4.sum}, 64'h0);
    chk("reset_w32", {29'b0, if32.out_valid, if32.overflow, if32.carry, if32.sum}, 64'h0);
    rst_n = 1'b1;

    // Single op, then a back-to-back burst, then one idle cycle.
    step(1'b1, 1'b1, 4'b0110, 4'b1100, 1'b0, {1'b0, 1'b1, 4'b0010});
    step(1'b1, 1'b1, 4'b1110, 4'b1000, 1'b0, {OvEn, 1'b1, 4'b0110});
    step(1'b1, 1'b1, 4'b0111, 4'b1110, 1'b0, {1'b0, 1'b1, 4'b0101});
    step(1'b1, 1'b1, 4'b0010, 4'b1001, 1'b0, {1'b0, 1'b0, 4'b1011});
    step(1'b0, 1'b0, 4'b0101, 4'b0101, 1'b1, 6'b0);
    @(negedge clk);
    #1;
    chk("idle_hold", {57'b0, if4.out_valid, if4.overflow, if4.carry, if4.sum},
        {57'b0, 1'b0, 1'b0, 1'b0, 4'b1011});

    // Wrap-around extremes and signed-overflow cases.
    step(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1, {1'b0, 1'b1, 4'b1111});
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, {1'b0, 1'b0, 4'b0000});
    step(1'b1, 1'b1, 4'b0111, 4'b0001, 1'b0, {OvEn, 1'b0, 4'b1000});
    step(1'b1, 1'b1, 4'b1000, 4'b1000, 1'b0, {OvEn, 1'b1, 4'b0000});
    step(1'b1, 1'b1, 4'b1011, 4'b1010, 1'b0, {OvEn, 1'b1, 4'b0101});

    // Operation in flight when reset hits mid-cycle: outputs clear at once, op is dropped.
    step(1'b1, 1'b0, 4'b0011, 4'b0001, 1'b0, 6'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_w4", {57'b0, if4.out_valid, if4.overflow, if4.carry, if4.sum}, 64'h0);
    chk("async_reset_w32", {29'b0, if32.out_valid, if32.overflow, if32.carry, if32.sum}, 64'h0);
    step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 6'b0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("discard_after_reset", {57'b0, if4.out_valid, if4.overflow, if4.carry, if4.sum}, 64'h0);

    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          step(1'b1, 1'b1, 4'(ia), 4'(ib), 1'(ic), model4(4'(ia), 4'(ib), 1'(ic)));
        end
      end
    end
    repeat (3) step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 6'b0);
    chk("drained", 64'(q4.size() + q1.size() + q32.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
